// File: rtl/psum_drain.sv
// Conv-kernel output stage: drains partial sums from the psum FIFO, adds bias,
// round-half-up shifts and saturates to OUT_W. Define PSUM_DRAIN_RELU_EN for ReLU.
module psum_drain #(
  parameter int DATA_W  = 28,
  parameter int OUT_W   = 8,
  parameter int BIAS_W  = 16,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_pix,
  input  logic signed [BIAS_W-1:0]  bias,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic signed [DATA_W-1:0]  fifo_data,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int AW        = DATA_W + 2;
  localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN_I = -(1 << (OUT_W - 1));
  localparam logic signed [AW-1:0] SAT_MAX = AW'(SAT_MAX_I);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(SAT_MIN_I);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  function automatic logic signed [AW-1:0] round_shift(
    input logic signed [DATA_W-1:0] d,
    input logic signed [BIAS_W-1:0] b,
    input logic [SHIFT_W-1:0]       sh
  );
    logic signed [AW-1:0] s;
    logic signed [AW-1:0] rnd;
    s   = AW'(d) + AW'(b);
    rnd = '0;
    if (sh != '0) rnd = AW'(1) << (sh - SHIFT_W'(1));
    s = s + rnd;
    return s >>> sh;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [AW-1:0] r_in);
    logic signed [AW-1:0] r;
    r = r_in;
`ifdef PSUM_DRAIN_RELU_EN
    if (r[AW-1]) r = '0;
`endif
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return OUT_W'(r);
  endfunction

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         issued_q, issued_d;
  logic [CNT_W-1:0]         npix_q, npix_d;
  logic signed [BIAS_W-1:0] bias_q, bias_d;
  logic [SHIFT_W-1:0]       shift_q, shift_d;
  logic                     inflight_q;
  logic signed [OUT_W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]               cnt_q, cnt_d;

  logic                     pop;
  logic [2:0]               occ;
  logic                     room;
  logic signed [OUT_W-1:0]  res;

  assign out_data  = buf0_q;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  // Occupancy counts the word still in flight from the FIFO's registered read.
  assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign room      = occ < (3'd2 + {2'b00, pop});
  assign res       = sat(round_shift(fifo_data, bias_q, shift_q));

  always_comb begin
    state_d    = state_q;
    npix_d     = npix_q;
    bias_d     = bias_q;
    shift_d    = shift_q;
    done       = 1'b0;
    fifo_rd_en = (state_q == S_RUN) && !fifo_empty && (issued_q < npix_q) && room;
    issued_d   = fifo_rd_en ? issued_q + CNT_W'(1) : issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          issued_d = '0;
          npix_d   = num_pix;
          bias_d   = bias;
          shift_d  = shift;
        end
      end
      S_RUN: begin
        if (issued_q == npix_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!inflight_q && cnt_q == 2'd0) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy = (state_q != S_IDLE) && !done;
  end

  // Two-entry in-order output buffer; push is the captured FIFO word.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = res;
        else               buf1_d = res;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = res;
        end else begin
          buf0_d = buf1_q;
          buf1_d = res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      npix_q     <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      npix_q     <= npix_d;
      bias_q     <= bias_d;
      shift_q    <= shift_d;
      inflight_q <= fifo_rd_en;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
